// File: rtl/clk_gate_sched_pkg.sv
// Shared state encoding and counter widths for the clock-gate scheduler.
package clk_gate_pkg;

   localparam int unsigned WAKE_W = 4;
   localparam int unsigned IDLE_W = 8;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      WAKE  = 2'd1,
      ON    = 2'd2,
      DRAIN = 2'd3
   } cg_state_t;

   // Width needed to count 0..n enabled domains.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/clk_gate_sched_if.sv
// Request/acknowledge bundle between the gated domains and the scheduler.
interface clk_gate_sched_if #(
   parameter int unsigned N = 4
);
   import clk_gate_pkg::*;

   localparam int unsigned CNT_W = cnt_width(N);

   logic [N-1:0]     REQ;
   logic [N-1:0]     BUSY;
   logic [N-1:0]     GEN;
   logic [N-1:0]     ACK;
   logic [CNT_W-1:0] ON_CNT;

   modport master (
      output REQ,
      output BUSY,
      input  GEN,
      input  ACK,
      input  ON_CNT
   );

   modport slave (
      input  REQ,
      input  BUSY,
      output GEN,
      output ACK,
      output ON_CNT
   );

endinterface

// File: rtl/clk_gate_sched_chan.sv
// Per-domain gate controller: OFF/WAKE/ON/DRAIN sequencing with wake and idle timers.
module clk_gate_chan
   import clk_gate_pkg::*;
#(
   parameter int unsigned WAKE_CYC = 2,
   parameter int unsigned IDLE_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic busy,
   input  logic grant,
   output logic gen,
   output logic ack,
   output logic off_c,
   output logic gen_nxt_c
);

   cg_state_t         state, state_nxt;
   logic [WAKE_W-1:0] wake_cnt, wake_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= OFF;
         wake_cnt <= '0;
         idle_cnt <= '0;
         gen      <= 1'b0;
         ack      <= 1'b0;
      end else begin
         state    <= state_nxt;
         wake_cnt <= wake_nxt;
         idle_cnt <= idle_nxt;
         gen      <= (state_nxt != OFF);
         ack      <= (state_nxt == ON);
      end
   end

   // Next-state: wake timer counts from grant; idle timer counts quiet cycles in DRAIN.
   always_comb begin
      state_nxt = state;
      wake_nxt  = wake_cnt;
      idle_nxt  = idle_cnt;
      case (state)
         OFF: begin
            if (grant) begin
               state_nxt = WAKE;
               wake_nxt  = '0;
            end
         end
         WAKE: begin
            if (wake_cnt == WAKE_W'(WAKE_CYC - 1)) begin
               state_nxt = req ? ON : DRAIN;
               idle_nxt  = '0;
            end else begin
               wake_nxt = wake_cnt + WAKE_W'(1);
            end
         end
         ON: begin
            if (!req) begin
               state_nxt = DRAIN;
               idle_nxt  = '0;
            end
         end
         DRAIN: begin
            if (req) begin
               state_nxt = ON;
            end else if (busy) begin
               idle_nxt = '0;
            end else begin
               idle_nxt = idle_cnt + IDLE_W'(1);
               if (idle_nxt == IDLE_W'(IDLE_CYC)) begin
                  state_nxt = OFF;
               end
            end
         end
         default: state_nxt = OFF;
      endcase
   end

   assign off_c     = (state == OFF);
   assign gen_nxt_c = (state_nxt != OFF);

endmodule

// File: rtl/clk_gate_sched.sv
// Clock-gate scheduler: round-robin grants under a global enabled-gate budget.
module clk_gate_sched
   import clk_gate_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_ON   = 2,
   parameter int unsigned WAKE_CYC = 2,
   parameter int unsigned IDLE_CYC = 16
) (
   input logic             CLK,
   input logic             R,
   clk_gate_sched_if.slave bus
);

   localparam int unsigned CNT_W = cnt_width(N);
   localparam int unsigned RR_W  = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]     gen, ack, off_c, gen_nxt_c, grant_c;
   logic [RR_W-1:0]  rr, gidx_c, idx_c;
   logic             found_c, budget_ok_c;
   logic [CNT_W-1:0] on_cnt, on_nxt_c;

   for (genvar i = 0; i < N; i++) begin : g_chan
      clk_gate_chan #(
         .WAKE_CYC (WAKE_CYC),
         .IDLE_CYC (IDLE_CYC)
      ) u_chan (
         .clk       (CLK),
         .rst_n     (R),
         .req       (bus.REQ[i]),
         .busy      (bus.BUSY[i]),
         .grant     (grant_c[i]),
         .gen       (gen[i]),
         .ack       (ack[i]),
         .off_c     (off_c[i]),
         .gen_nxt_c (gen_nxt_c[i])
      );
   end

   // Round-robin search from rr over OFF domains that are requesting.
   always_comb begin
      grant_c     = '0;
      found_c     = 1'b0;
      gidx_c      = '0;
      idx_c       = '0;
      budget_ok_c = (on_cnt < CNT_W'(MAX_ON));
      for (int unsigned i = 0; i < N; i++) begin
         idx_c = RR_W'((32'(rr) + i) % N);
         if (!found_c && off_c[idx_c] && bus.REQ[idx_c]) begin
            found_c = 1'b1;
            gidx_c  = idx_c;
         end
      end
      if (found_c && budget_ok_c) begin
         grant_c[gidx_c] = 1'b1;
      end
   end

   // Count uses next-cycle gate enables so ON_CNT tracks GEN exactly.
   always_comb begin
      on_nxt_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         on_nxt_c = on_nxt_c + CNT_W'(gen_nxt_c[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (!R) begin
         rr     <= '0;
         on_cnt <= '0;
      end else begin
         on_cnt <= on_nxt_c;
         if (found_c && budget_ok_c) begin
            rr <= RR_W'((32'(gidx_c) + 32'd1) % N);
         end
      end
   end

   assign bus.GEN    = gen;
   assign bus.ACK    = ack;
   assign bus.ON_CNT = on_cnt;

endmodule

// File: tb/tb_clk_gate_sched.sv
// Directed and randomized checks of clk_gate_sched against a cycle-level reference model.
module tb_clk_gate_sched;

   localparam int unsigned N        = 4;
   localparam int unsigned MAX_ON   = 2;
   localparam int unsigned WAKE_CYC = 2;
   localparam int unsigned IDLE_CYC = 16;
   localparam int unsigned CNT_W    = $clog2(N + 1);

   localparam int M_OFF   = 0;
   localparam int M_WAKE  = 1;
   localparam int M_ON    = 2;
   localparam int M_DRAIN = 3;

   logic CLK = 1'b0;
   logic R;

   clk_gate_sched_if #(.N(N)) bus ();

   clk_gate_sched #(
      .N        (N),
      .MAX_ON   (MAX_ON),
      .WAKE_CYC (WAKE_CYC),
      .IDLE_CYC (IDLE_CYC)
   ) dut (
      .CLK (CLK),
      .R   (R),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Reference model: per-domain mode, remaining wake cycles, idle cycles seen.
   int m_mode [N];
   int m_wake [N];
   int m_idle [N];
   int m_rr;

   function automatic logic [N-1:0] exp_gen();
      logic [N-1:0] v = '0;
      for (int d = 0; d < N; d++) v[d] = (m_mode[d] != M_OFF);
      return v;
   endfunction

   function automatic logic [N-1:0] exp_ack();
      logic [N-1:0] v = '0;
      for (int d = 0; d < N; d++) v[d] = (m_mode[d] == M_ON);
      return v;
   endfunction

   function automatic int exp_cnt();
      int c = 0;
      for (int d = 0; d < N; d++) if (m_mode[d] != M_OFF) c++;
      return c;
   endfunction

   task automatic model_step();
      int  cnt;
      int  g;
      int  dd;
      if (!R) begin
         for (int d = 0; d < N; d++) begin
            m_mode[d] = M_OFF;
            m_wake[d] = 0;
            m_idle[d] = 0;
         end
         m_rr = 0;
      end else begin
         cnt = exp_cnt();
         g   = -1;
         if (cnt < int'(MAX_ON)) begin
            for (int k = 0; k < N; k++) begin
               dd = (m_rr + k) % N;
               if (g < 0 && m_mode[dd] == M_OFF && bus.REQ[dd]) g = dd;
            end
         end
         for (int d = 0; d < N; d++) begin
            case (m_mode[d])
               M_OFF: if (d == g) begin
                  m_mode[d] = M_WAKE;
                  m_wake[d] = WAKE_CYC;
               end
               M_WAKE: begin
                  m_wake[d]--;
                  if (m_wake[d] == 0) begin
                     m_mode[d] = bus.REQ[d] ? M_ON : M_DRAIN;
                     m_idle[d] = 0;
                  end
               end
               M_ON: if (!bus.REQ[d]) begin
                  m_mode[d] = M_DRAIN;
                  m_idle[d] = 0;
               end
               default: begin
                  if (bus.REQ[d]) m_mode[d] = M_ON;
                  else if (bus.BUSY[d]) m_idle[d] = 0;
                  else begin
                     m_idle[d]++;
                     if (m_idle[d] == int'(IDLE_CYC)) m_mode[d] = M_OFF;
                  end
               end
            endcase
         end
         if (g >= 0) m_rr = (g + 1) % N;
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      R        = 1'b0;
      bus.REQ  = '0;
      bus.BUSY = '0;
      cycle();
      R = 1'b1;
   endtask

   task automatic test_reset();
      R        = 1'b0;
      bus.REQ  = '1;
      bus.BUSY = '1;
      cycle();
      cycle();
      checks++;
      if (bus.GEN !== 4'b0000 || bus.ACK !== 4'b0000 || bus.ON_CNT !== 3'd0) begin
         failures++;
         $display("FAIL reset gen=%b ack=%b cnt=%0d required 0000/0000/0", bus.GEN, bus.ACK, bus.ON_CNT);
      end
      bus.REQ  = '0;
      bus.BUSY = '0;
      R        = 1'b1;
   endtask

   task automatic test_single_wake();
      do_reset();
      bus.REQ = 4'b0001;
      cycle();
      checks++;
      if (bus.GEN !== 4'b0001 || bus.ACK !== 4'b0000 || bus.ON_CNT !== 3'd1) begin
         failures++;
         $display("FAIL wake_grant gen=%b ack=%b cnt=%0d required 0001/0000/1", bus.GEN, bus.ACK, bus.ON_CNT);
      end
      cycle();
      checks++;
      if (bus.ACK !== 4'b0000) begin
         failures++;
         $display("FAIL wake_early_ack ack=%b required 0000", bus.ACK);
      end
      cycle();
      checks++;
      if (bus.ACK !== 4'b0001 || bus.ON_CNT !== 3'd1) begin
         failures++;
         $display("FAIL wake_ack ack=%b cnt=%0d required 0001/1", bus.ACK, bus.ON_CNT);
      end
   endtask

   task automatic test_budget_rr();
      do_reset();
      bus.REQ = 4'b1111;
      cycle();
      checks++;
      if (bus.GEN !== 4'b0001 || bus.ON_CNT !== 3'd1) begin
         failures++;
         $display("FAIL budget_first gen=%b cnt=%0d required 0001/1", bus.GEN, bus.ON_CNT);
      end
      cycle();
      checks++;
      if (bus.GEN !== 4'b0011 || bus.ON_CNT !== 3'd2) begin
         failures++;
         $display("FAIL budget_second gen=%b cnt=%0d required 0011/2", bus.GEN, bus.ON_CNT);
      end
      repeat (6) cycle();
      checks++;
      if (bus.GEN !== 4'b0011 || bus.ACK !== 4'b0011 || bus.ON_CNT !== 3'd2) begin
         failures++;
         $display("FAIL budget_full gen=%b ack=%b cnt=%0d required 0011/0011/2", bus.GEN, bus.ACK, bus.ON_CNT);
      end
      bus.REQ = 4'b1110;
      cycle();
      checks++;
      if (bus.ACK !== 4'b0010 || bus.GEN !== 4'b0011) begin
         failures++;
         $display("FAIL budget_drop ack=%b gen=%b required 0010/0011", bus.ACK, bus.GEN);
      end
      repeat (IDLE_CYC - 1) cycle();
      checks++;
      if (bus.GEN !== 4'b0011) begin
         failures++;
         $display("FAIL budget_hold gen=%b required 0011", bus.GEN);
      end
      cycle();
      checks++;
      if (bus.GEN !== 4'b0010 || bus.ON_CNT !== 3'd1) begin
         failures++;
         $display("FAIL budget_regate gen=%b cnt=%0d required 0010/1", bus.GEN, bus.ON_CNT);
      end
      cycle();
      checks++;
      if (bus.GEN !== 4'b0110 || bus.ON_CNT !== 3'd2) begin
         failures++;
         $display("FAIL budget_next_rr gen=%b cnt=%0d required 0110/2", bus.GEN, bus.ON_CNT);
      end
   endtask

   task automatic test_busy_drain();
      do_reset();
      bus.REQ = 4'b0001;
      repeat (3) cycle();
      bus.REQ = 4'b0000;
      cycle();
      checks++;
      if (bus.ACK !== 4'b0000 || bus.GEN !== 4'b0001) begin
         failures++;
         $display("FAIL busy_ack_drop ack=%b gen=%b required 0000/0001", bus.ACK, bus.GEN);
      end
      repeat (10) cycle();
      bus.BUSY = 4'b0001;
      cycle();
      bus.BUSY = 4'b0000;
      repeat (IDLE_CYC - 1) cycle();
      checks++;
      if (bus.GEN !== 4'b0001) begin
         failures++;
         $display("FAIL busy_extend gen=%b required 0001", bus.GEN);
      end
      cycle();
      checks++;
      if (bus.GEN !== 4'b0000 || bus.ON_CNT !== 3'd0) begin
         failures++;
         $display("FAIL busy_regate gen=%b cnt=%0d required 0000/0", bus.GEN, bus.ON_CNT);
      end
   endtask

   task automatic test_req_reassert();
      do_reset();
      bus.REQ = 4'b0001;
      repeat (3) cycle();
      bus.REQ = 4'b0000;
      repeat (5) cycle();
      bus.REQ = 4'b0001;
      cycle();
      checks++;
      if (bus.ACK !== 4'b0001 || bus.GEN !== 4'b0001 || bus.ON_CNT !== 3'd1) begin
         failures++;
         $display("FAIL reassert ack=%b gen=%b cnt=%0d required 0001/0001/1", bus.ACK, bus.GEN, bus.ON_CNT);
      end
   endtask

   task automatic test_wake_abort();
      int ack_seen = 0;
      int gen_fall = -1;
      do_reset();
      bus.REQ = 4'b0001;
      cycle();
      bus.REQ = 4'b0000;
      for (int k = 1; k <= int'(WAKE_CYC + IDLE_CYC) + 2; k++) begin
         cycle();
         if (bus.ACK[0]) ack_seen++;
         if (gen_fall < 0 && !bus.GEN[0]) gen_fall = k;
      end
      checks++;
      if (ack_seen != 0) begin
         failures++;
         $display("FAIL abort_ack ack_cycles=%0d required 0", ack_seen);
      end
      checks++;
      if (gen_fall != int'(WAKE_CYC + IDLE_CYC)) begin
         failures++;
         $display("FAIL abort_regate gen_fall_cycle=%0d required %0d", gen_fall, WAKE_CYC + IDLE_CYC);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.REQ = 4'b0011;
      repeat (4) cycle();
      checks++;
      if (bus.ACK !== 4'b0011 || bus.ON_CNT !== 3'd2) begin
         failures++;
         $display("FAIL mid_setup ack=%b cnt=%0d required 0011/2", bus.ACK, bus.ON_CNT);
      end
      R       = 1'b0;
      bus.REQ = 4'b1010;
      cycle();
      checks++;
      if (bus.GEN !== 4'b0000 || bus.ACK !== 4'b0000 || bus.ON_CNT !== 3'd0) begin
         failures++;
         $display("FAIL mid_reset gen=%b ack=%b cnt=%0d required 0000/0000/0", bus.GEN, bus.ACK, bus.ON_CNT);
      end
      R = 1'b1;
      cycle();
      checks++;
      if (bus.GEN !== 4'b0010 || bus.ON_CNT !== 3'd1) begin
         failures++;
         $display("FAIL mid_first_grant gen=%b cnt=%0d required 0010/1", bus.GEN, bus.ON_CNT);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         R = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
         for (int d = 0; d < N; d++) begin
            if (bus.REQ[d]) begin
               if ($urandom_range(0, 7) == 0) bus.REQ[d] = 1'b0;
            end else begin
               if ($urandom_range(0, 29) == 0) bus.REQ[d] = 1'b1;
            end
            bus.BUSY[d] = ($urandom_range(0, 15) == 0);
         end
         cycle();
         checks++;
         if (bus.GEN !== exp_gen() || bus.ACK !== exp_ack() || bus.ON_CNT !== CNT_W'(exp_cnt())) begin
            failures++;
            $display("FAIL random cyc=%0d gen=%b ack=%b cnt=%0d required %b/%b/%0d",
                     c, bus.GEN, bus.ACK, bus.ON_CNT, exp_gen(), exp_ack(), exp_cnt());
         end
         checks++;
         if (bus.ON_CNT > CNT_W'(MAX_ON)) begin
            failures++;
            $display("FAIL random_budget cyc=%0d cnt=%0d required <=%0d", c, bus.ON_CNT, MAX_ON);
         end
      end
   endtask

   initial begin
      R        = 1'b0;
      bus.REQ  = '0;
      bus.BUSY = '0;
      m_rr     = 0;
      for (int d = 0; d < N; d++) begin
         m_mode[d] = M_OFF;
         m_wake[d] = 0;
         m_idle[d] = 0;
      end
      test_reset();
      test_single_wake();
      test_budget_rr();
      test_busy_drain();
      test_req_reassert();
      test_wake_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
